// File: rtl/clk_div_bank_if.sv
// Bus between a controller and the clock divider bank: per-channel run/mode
// controls, divisor write strobes, the global resync strobe and the divided
// outputs.
//
// Handshake: div_wr and resync are single-cycle strobes that act on the clock
// edge where they are sampled high. There is no ready or back-pressure path,
// so every strobe is accepted on that edge. start and mode are level inputs.
interface clk_div_bank_if #(
    parameter int CHANNELS = 4,
    parameter int DIV_W    = 26
);
    logic [CHANNELS-1:0] start;
    logic [CHANNELS-1:0] mode;
    logic [CHANNELS-1:0] div_wr;
    logic [DIV_W-1:0]    div_data;
    logic                resync;
    logic [CHANNELS-1:0] slow_clk;
    logic [CHANNELS-1:0] tick;
    logic [CHANNELS-1:0] pending;

    modport master (
        output start, mode, div_wr, div_data, resync,
        input  slow_clk, tick, pending
    );

    modport slave (
        input  start, mode, div_wr, div_data, resync,
        output slow_clk, tick, pending
    );
endinterface

// File: rtl/clk_div_bank.sv
// Bank of independent programmable clock dividers. Each channel counts system
// clocks up to its active divisor D and produces either a 50% square wave
// (period 2*D) or a one-cycle pulse train (period D), plus a tick at every
// completed output period. New divisors go through a shadow register and
// only take effect at a full-period boundary or on resync, so an output
// period is never cut short.
module clk_div_bank #(
    parameter int CHANNELS = 4,
    parameter int DIV_W    = 26
) (
    input  logic         clk,
    input  logic         reset,
    clk_div_bank_if.slave bus
);

    logic [DIV_W-1:0]    div_q    [CHANNELS];
    logic [DIV_W-1:0]    shadow_q [CHANNELS];
    logic [DIV_W-1:0]    cnt_q    [CHANNELS];
    logic [CHANNELS-1:0] pending_q;
    logic [CHANNELS-1:0] phase_q;
    logic [CHANNELS-1:0] mode_q;
    logic [CHANNELS-1:0] slow_q;
    logic [CHANNELS-1:0] tick_q;

    logic [CHANNELS-1:0] running;
    logic [CHANNELS-1:0] wrap;
    logic [CHANNELS-1:0] boundary;

    // Run status, counter wrap and full-period boundary for every channel.
    // In toggle mode only the wrap that brings phase back to 0 closes a period.
    always_comb begin
        running  = '0;
        wrap     = '0;
        boundary = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            running[i]  = bus.start[i] && (div_q[i] != '0);
            wrap[i]     = running[i] && (cnt_q[i] == div_q[i] - DIV_W'(1));
            boundary[i] = wrap[i] && (mode_q[i] || phase_q[i]);
        end
    end

    // Per-channel counter, output, divisor and mode registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                div_q[i]    <= '0;
                shadow_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
            pending_q <= '0;
            phase_q   <= '0;
            mode_q    <= '0;
            slow_q    <= '0;
            tick_q    <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                // Counter and output path; resync overrides normal counting.
                if (div_q[i] == '0) begin
                    cnt_q[i]   <= '0;
                    phase_q[i] <= 1'b0;
                    slow_q[i]  <= 1'b0;
                    tick_q[i]  <= 1'b0;
                end else if (!bus.start[i]) begin
                    cnt_q[i]   <= '0;
                    phase_q[i] <= 1'b0;
                    slow_q[i]  <= ~bus.mode[i];
                    tick_q[i]  <= 1'b0;
                end else if (bus.resync) begin
                    cnt_q[i]   <= '0;
                    phase_q[i] <= 1'b0;
                    slow_q[i]  <= ~mode_q[i];
                    tick_q[i]  <= 1'b0;
                end else begin
                    cnt_q[i]   <= wrap[i] ? '0 : cnt_q[i] + DIV_W'(1);
                    phase_q[i] <= phase_q[i] ^ wrap[i];
                    slow_q[i]  <= mode_q[i] ? wrap[i] : ~(phase_q[i] ^ wrap[i]);
                    tick_q[i]  <= boundary[i];
                end

                // Divisor update: a write that lands where D may change right
                // now bypasses the shadow; otherwise it waits as pending.
                if (bus.div_wr[i]) begin
                    shadow_q[i] <= bus.div_data;
                    if (!running[i] || bus.resync || boundary[i]) begin
                        div_q[i]     <= bus.div_data;
                        pending_q[i] <= 1'b0;
                    end else begin
                        pending_q[i] <= 1'b1;
                    end
                end else if (pending_q[i] && (bus.resync || boundary[i])) begin
                    div_q[i]     <= shadow_q[i];
                    pending_q[i] <= 1'b0;
                end

                // Mode is latched only while the channel is not running.
                if (!running[i]) begin
                    mode_q[i] <= bus.mode[i];
                end
            end
        end
    end

    assign bus.slow_clk = slow_q;
    assign bus.tick     = tick_q;
    assign bus.pending  = pending_q;

endmodule

// File: tb/tb_clk_div_bank.sv
// Testbench for clk_div_bank: directed scenarios followed by random traffic,
// all cycles compared against a period-position reference model.
module tb_clk_div_bank;

  localparam int CH = 4;
  localparam int DW = 26;

  logic clk;
  logic reset;

  clk_div_bank_if #(.CHANNELS(CH), .DIV_W(DW)) bus ();

  clk_div_bank #(.CHANNELS(CH), .DIV_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;

  logic [3*CH-1:0] exp_q[$];

  // reference model: position k inside the current full output period
  int        m_d [CH];
  int        m_s [CH];
  int        m_k [CH];
  logic [CH-1:0] m_pend;
  logic [CH-1:0] m_m;
  logic [CH-1:0] m_slow;
  logic [CH-1:0] m_tick;

  logic [CH-1:0] cur_st;
  logic [CH-1:0] cur_md;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_d[i] = 0;
      m_s[i] = 0;
      m_k[i] = 0;
    end
    m_pend = '0;
    m_m    = '0;
    m_slow = '0;
    m_tick = '0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic [CH-1:0] st, input logic [CH-1:0] md,
                            input logic [CH-1:0] wr, input int dd, input logic rs);
    for (int i = 0; i < CH; i++) begin
      bit run;
      bit bnd;
      int p;
      run = st[i] && (m_d[i] != 0);
      bnd = 1'b0;
      if (m_d[i] == 0) begin
        m_k[i] = 0; m_slow[i] = 1'b0; m_tick[i] = 1'b0;
      end else if (!st[i]) begin
        m_k[i] = 0; m_slow[i] = !md[i]; m_tick[i] = 1'b0;
      end else if (rs) begin
        m_k[i] = 0; m_slow[i] = !m_m[i]; m_tick[i] = 1'b0;
      end else begin
        p = m_m[i] ? m_d[i] : 2 * m_d[i];
        m_k[i] = m_k[i] + 1;
        if (m_k[i] == p) begin
          m_k[i] = 0;
          bnd = 1'b1;
        end
        m_slow[i] = m_m[i] ? (m_k[i] == 0) : (m_k[i] < m_d[i]);
        m_tick[i] = bnd;
      end
      if (wr[i]) begin
        m_s[i] = dd;
        if (!run || rs || bnd) begin
          m_d[i] = dd;
          m_pend[i] = 1'b0;
        end else begin
          m_pend[i] = 1'b1;
        end
      end else if (m_pend[i] && (rs || bnd)) begin
        m_d[i] = m_s[i];
        m_pend[i] = 1'b0;
      end
      if (!run) m_m[i] = md[i];
    end
  endtask

  // driver: one clock with current start/mode plus the given strobes
  task automatic step(input logic [CH-1:0] wr, input logic [DW-1:0] dd, input logic rs);
    logic [3*CH-1:0] exp;
    bus.start    = cur_st;
    bus.mode     = cur_md;
    bus.div_wr   = wr;
    bus.div_data = dd;
    bus.resync   = rs;
    model_step(cur_st, cur_md, wr, int'(dd), rs);
    exp_q.push_back({m_slow, m_tick, m_pend});
    @(posedge clk);
    @(negedge clk);
    exp = exp_q.pop_front();
    check("slow_clk", 32'(bus.slow_clk), 32'(exp[3*CH-1:2*CH]));
    check("tick",     32'(bus.tick),     32'(exp[2*CH-1:CH]));
    check("pending",  32'(bus.pending),  32'(exp[CH-1:0]));
  endtask

  task automatic idle(input int n);
    repeat (n) step('0, '0, 1'b0);
  endtask

  task automatic run_until_tick(input int ch, output int n);
    n = -1;
    for (int j = 1; j <= 50; j++) begin
      step('0, '0, 1'b0);
      if (bus.tick[ch]) begin
        n = j;
        break;
      end
    end
  endtask

  int tog_slow [12] = '{1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1};
  int tog_tick [12] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
  int pul_slow [5]  = '{0, 0, 0, 0, 1};

  initial begin
    int n;
    int f0;
    int f3;
    logic [CH-1:0] wr;
    logic rs;

    reset = 1'b1;
    cur_st = '0;
    cur_md = '0;
    bus.start = '0; bus.mode = '0; bus.div_wr = '0; bus.div_data = '0; bus.resync = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_slow",    32'(bus.slow_clk), 32'h0);
    check("rst_tick",    32'(bus.tick),     32'h0);
    check("rst_pending", 32'(bus.pending),  32'h0);
    reset = 1'b0;
    model_reset();

    // toggle: ch0 D=3
    step(4'b0001, 26'd3, 1'b0);
    check("tog_wr_no_pend", 32'(bus.pending[0]), 32'h0);
    idle(1);
    check("tog_idle_high", 32'(bus.slow_clk[0]), 32'h1);
    cur_st[0] = 1'b1;
    for (int j = 0; j < 12; j++) begin
      idle(1);
      check("tog_slow_pat", 32'(bus.slow_clk[0]), 32'(tog_slow[j]));
      check("tog_tick_pat", 32'(bus.tick[0]),     32'(tog_tick[j]));
    end

    // pulse: ch1 D=5, mode changes while running are ignored
    cur_md[1] = 1'b1;
    step(4'b0010, 26'd5, 1'b0);
    idle(1);
    check("pul_idle_low", 32'(bus.slow_clk[1]), 32'h0);
    cur_st[1] = 1'b1;
    for (int j = 0; j < 10; j++) begin
      if (j == 5) cur_md[1] = 1'b0;
      idle(1);
      check("pul_slow_pat", 32'(bus.slow_clk[1]), 32'(pul_slow[j % 5]));
      check("pul_tick_eq",  32'(bus.tick[1]),     32'(pul_slow[j % 5]));
    end
    cur_st[1] = 1'b0;
    idle(1);
    check("pul_stop_idle", 32'(bus.slow_clk[1]), 32'h1);

    // shadow load: ch2 D=4, write 2 mid-period
    step(4'b0100, 26'd4, 1'b0);
    cur_st[2] = 1'b1;
    idle(3);
    step(4'b0100, 26'd2, 1'b0);
    check("shd_pending_set", 32'(bus.pending[2]), 32'h1);
    run_until_tick(2, n);
    check("shd_old_period_rest", 32'(n), 32'd4);
    check("shd_pending_clr", 32'(bus.pending[2]), 32'h0);
    run_until_tick(2, n);
    check("shd_new_period", 32'(n), 32'd4);

    // resync: ch0 D=3 running, ch3 D=5 started later
    step(4'b1000, 26'd5, 1'b0);
    cur_st[3] = 1'b1;
    idle(7);
    step('0, '0, 1'b1);
    check("rsy_idle_ch0", 32'(bus.slow_clk[0]), 32'h1);
    check("rsy_idle_ch3", 32'(bus.slow_clk[3]), 32'h1);
    check("rsy_no_tick",  32'({bus.tick[3], bus.tick[0]}), 32'h0);
    f0 = 0;
    f3 = 0;
    for (int j = 1; j <= 30; j++) begin
      idle(1);
      if (f0 == 0 && !bus.slow_clk[0]) f0 = j;
      if (f3 == 0 && !bus.slow_clk[3]) f3 = j;
      if (j == 30) check("rsy_coincide", 32'({bus.tick[3], bus.tick[0]}), 32'h3);
    end
    check("rsy_fall_ch0", 32'(f0), 32'd3);
    check("rsy_fall_ch3", 32'(f3), 32'd5);

    // boundary write: 6 into running ch0 exactly on its boundary edge
    for (int j = 0; j < 20; j++) begin
      if (m_k[0] == 5) break;
      idle(1);
    end
    step(4'b0001, 26'd6, 1'b0);
    check("bwr_no_pend", 32'(bus.pending[0]), 32'h0);
    check("bwr_tick",    32'(bus.tick[0]),    32'h1);
    run_until_tick(0, n);
    check("bwr_period", 32'(n), 32'd12);

    // reset mid-run: ch0 back to D=3, pending write on ch2
    cur_st[0] = 1'b0;
    step(4'b0001, 26'd3, 1'b0);
    cur_st[0] = 1'b1;
    idle(4);
    for (int j = 0; j < 10; j++) begin
      if (m_k[2] == 1) break;
      idle(1);
    end
    step(4'b0100, 26'd5, 1'b0);
    check("rst_pre_pending", 32'(bus.pending[2]), 32'h1);
    reset = 1'b1;
    #1;
    check("arst_slow",    32'(bus.slow_clk), 32'h0);
    check("arst_tick",    32'(bus.tick),     32'h0);
    check("arst_pending", 32'(bus.pending),  32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    cur_st = '1;
    cur_md = '0;
    for (int j = 0; j < 20; j++) begin
      idle(1);
      check("post_rst_slow", 32'(bus.slow_clk), 32'h0);
    end

    // random traffic
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < CH; b++) begin
        if ($urandom_range(0, 15) == 0) cur_st[b] = ~cur_st[b];
        if ($urandom_range(0, 7) == 0)  cur_md[b] = ~cur_md[b];
        wr[b] = ($urandom_range(0, 7) == 0);
      end
      rs = ($urandom_range(0, 31) == 0);
      step(wr, DW'($urandom_range(0, 6)), rs);
    end

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
